init_seq_num_ctrl: RTL and testbench

Controller for the `init_seq_num_mem` write port. It performs the post-reset clear sweep of every flow entry. It then arbitrates flow-open requests from two sources (RX SYN path = src 0, TX connect path = src 1) and computes each ISN as a free-running ISN clock plus a requester-supplied salt. It writes the ISN into the memory and returns it to the requester. Read ports of the memory are untouched and stay with their consumers.

---
 rtl/init_seq_num_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_init_seq_num_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/init_seq_num_ctrl.sv
// rtl/init_seq_num_ctrl.sv - ISN memory write-port controller: clear sweep, open arbitration, ISN generation
module init_seq_num_ctrl #(
    parameter int width_p    = 32,
    parameter int els_p      = 8,
    parameter int addr_w     = (els_p > 1) ? $clog2(els_p) : 1,
    parameter int tick_div_p = 4
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               open0_req_val,
    input  logic [addr_w-1:0]  open0_req_flowid,
    input  logic [width_p-1:0] open0_req_salt,
    output logic               open0_req_rdy,

    input  logic               open1_req_val,
    input  logic [addr_w-1:0]  open1_req_flowid,
    input  logic [width_p-1:0] open1_req_salt,
    output logic               open1_req_rdy,

    output logic               done_val,
    output logic               done_src,
    output logic [addr_w-1:0]  done_flowid,
    output logic [width_p-1:0] done_isn,
    input  logic               done_rdy,

    output logic               isn_wr_req_val,
    output logic [addr_w-1:0]  isn_wr_req_addr,
    output logic [width_p-1:0] isn_wr_req_num,
    input  logic               isn_wr_req_rdy,

    output logic               init_done
);

    localparam int presc_w = (tick_div_p > 1) ? $clog2(tick_div_p) : 1;
    localparam logic [presc_w-1:0] presc_max = presc_w'(tick_div_p - 1);
    localparam logic [addr_w-1:0]  last_idx  = addr_w'(els_p - 1);

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_IDLE  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [addr_w-1:0]    clr_idx_q, clr_idx_d;
    logic [width_p-1:0]   isn_clk_q, isn_clk_d;
    logic [presc_w-1:0]   presc_q, presc_d;
    logic                 ptr_q, ptr_d;
    logic                 src_q, src_d;
    logic [addr_w-1:0]    flowid_q, flowid_d;
    logic [width_p-1:0]   isn_q, isn_d;

    logic                 any_req;
    logic                 win_src;
    logic                 grant;

    // Round-robin pick: the pointer only matters when both sources ask at once
    always_comb begin
        any_req = open0_req_val | open1_req_val;
        if (open0_req_val && open1_req_val) begin
            win_src = ptr_q;
        end else begin
            win_src = open1_req_val;
        end
        grant = (state_q == S_IDLE) && any_req;
    end

    // Free-running ISN clock: prescaler wraps at tick_div_p-1 and bumps the counter
    always_comb begin
        if (presc_q == presc_max) begin
            presc_d   = '0;
            isn_clk_d = isn_clk_q + width_p'(1);
        end else begin
            presc_d   = presc_q + presc_w'(1);
            isn_clk_d = isn_clk_q;
        end
    end

    // ISN clock registers run in every state
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q   <= '0;
            isn_clk_q <= '0;
        end else begin
            presc_q   <= presc_d;
            isn_clk_q <= isn_clk_d;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // Sweep index, arbitration pointer and latched open request
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_idx_q <= '0;
            ptr_q     <= 1'b0;
            src_q     <= 1'b0;
            flowid_q  <= '0;
            isn_q     <= '0;
        end else begin
            clr_idx_q <= clr_idx_d;
            ptr_q     <= ptr_d;
            src_q     <= src_d;
            flowid_q  <= flowid_d;
            isn_q     <= isn_d;
        end
    end

    // Next-state logic; the ISN is the clock value seen in the grant cycle plus the salt
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        ptr_d     = ptr_q;
        src_d     = src_q;
        flowid_d  = flowid_q;
        isn_d     = isn_q;
        case (state_q)
            S_CLEAR: begin
                if (isn_wr_req_rdy) begin
                    if (clr_idx_q == last_idx) begin
                        state_d = S_IDLE;
                    end else begin
                        clr_idx_d = clr_idx_q + addr_w'(1);
                    end
                end
            end
            S_IDLE: begin
                if (grant) begin
                    src_d    = win_src;
                    flowid_d = win_src ? open1_req_flowid : open0_req_flowid;
                    isn_d    = isn_clk_q + (win_src ? open1_req_salt : open0_req_salt);
                    ptr_d    = ~win_src;
                    state_d  = S_WRITE;
                end
            end
            S_WRITE: begin
                if (isn_wr_req_rdy) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (done_rdy) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_CLEAR;
            end
        endcase
    end

    // Outputs, all forced low while reset is held
    always_comb begin
        open0_req_rdy   = 1'b0;
        open1_req_rdy   = 1'b0;
        done_val        = 1'b0;
        done_src        = 1'b0;
        done_flowid     = '0;
        done_isn        = '0;
        isn_wr_req_val  = 1'b0;
        isn_wr_req_addr = '0;
        isn_wr_req_num  = '0;
        init_done       = 1'b0;
        if (!rst) begin
            case (state_q)
                S_CLEAR: begin
                    isn_wr_req_val  = 1'b1;
                    isn_wr_req_addr = clr_idx_q;
                end
                S_IDLE: begin
                    init_done     = 1'b1;
                    open0_req_rdy = open0_req_val && !win_src;
                    open1_req_rdy = open1_req_val && win_src;
                end
                S_WRITE: begin
                    init_done       = 1'b1;
                    isn_wr_req_val  = 1'b1;
                    isn_wr_req_addr = flowid_q;
                    isn_wr_req_num  = isn_q;
                end
                S_DONE: begin
                    init_done   = 1'b1;
                    done_val    = 1'b1;
                    done_src    = src_q;
                    done_flowid = flowid_q;
                    done_isn    = isn_q;
                end
                default: begin
                    init_done = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_init_seq_num_ctrl.sv
// tb/tb_init_seq_num_ctrl.sv - self-checking bench for init_seq_num_ctrl
module tb_init_seq_num_ctrl;

    localparam int W  = 32;
    localparam int E  = 8;
    localparam int AW = 3;
    localparam int TD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          v0 = 1'b0, v1 = 1'b0;
    logic [AW-1:0] f0 = '0, f1 = '0;
    logic [W-1:0]  s0 = '0, s1 = '0;
    logic          done_rdy = 1'b0, wr_rdy = 1'b0;
    logic          rdy0, rdy1, done_val, done_src, wr_val, init_done;
    logic [AW-1:0] done_flowid, wr_addr;
    logic [W-1:0]  done_isn, wr_num;

    always #5 clk = ~clk;

    init_seq_num_ctrl #(.width_p(W), .els_p(E), .addr_w(AW), .tick_div_p(TD)) dut (
        .clk(clk), .rst(rst),
        .open0_req_val(v0), .open0_req_flowid(f0), .open0_req_salt(s0), .open0_req_rdy(rdy0),
        .open1_req_val(v1), .open1_req_flowid(f1), .open1_req_salt(s1), .open1_req_rdy(rdy1),
        .done_val(done_val), .done_src(done_src), .done_flowid(done_flowid), .done_isn(done_isn),
        .done_rdy(done_rdy),
        .isn_wr_req_val(wr_val), .isn_wr_req_addr(wr_addr), .isn_wr_req_num(wr_num),
        .isn_wr_req_rdy(wr_rdy),
        .init_done(init_done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: cycle count since reset release, clear progress, pointer, pending open
    typedef struct {
        logic          src;
        logic [AW-1:0] flow;
        logic [W-1:0]  isn;
        logic          written;
    } open_t;
    open_t pend[$];
    int    c = 0;
    int    cleared = 0;
    logic  ptr = 1'b0;
    int    gq[$];

    logic          sn_init, sn_r0, sn_r1, sn_wv, sn_dv, sn_ds;
    logic [AW-1:0] sn_wa, sn_df;
    logic [W-1:0]  sn_wn, sn_di;
    logic          sn_hs0, sn_hs1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, c);
        end
    endtask

    task automatic tick(input string tag);
        logic          e_init, e_r0, e_r1, e_wv, e_dv, e_ds;
        logic [AW-1:0] e_wa, e_df;
        logic [W-1:0]  e_wn, e_di, clk_v;
        logic          o_r0, o_r1;
        logic [AW-1:0] o_wa, o_df;
        logic [W-1:0]  o_wn, o_di;
        logic          o_ds;
        logic          gnt, gsrc, hs_clr, hs_wr, hs_done;
        open_t         t;
        @(negedge clk);
        e_init = 0; e_r0 = 0; e_r1 = 0; e_wv = 0; e_dv = 0; e_ds = 0;
        e_wa = '0; e_df = '0; e_wn = '0; e_di = '0;
        gnt = 0; gsrc = 0; hs_clr = 0; hs_wr = 0; hs_done = 0;
        clk_v = W'(c / TD);
        if (!rst) begin
            if (cleared < E) begin
                e_wv = 1; e_wa = AW'(cleared); hs_clr = wr_rdy;
            end else begin
                e_init = 1;
                if (pend.size() == 0) begin
                    if (v0 && v1) begin gnt = 1; gsrc = ptr; end
                    else if (v0 || v1) begin gnt = 1; gsrc = v1; end
                    e_r0 = gnt && !gsrc;
                    e_r1 = gnt && gsrc;
                end else if (!pend[0].written) begin
                    e_wv = 1; e_wa = pend[0].flow; e_wn = pend[0].isn; hs_wr = wr_rdy;
                end else begin
                    e_dv = 1; e_ds = pend[0].src; e_df = pend[0].flow; e_di = pend[0].isn;
                    hs_done = done_rdy;
                end
            end
        end
        o_r0 = rst ? rdy0 : (rdy0 & v0);
        o_r1 = rst ? rdy1 : (rdy1 & v1);
        o_wa = (rst || wr_val) ? wr_addr : '0;
        o_wn = (rst || wr_val) ? wr_num : '0;
        o_ds = (rst || done_val) ? done_src : 1'b0;
        o_df = (rst || done_val) ? done_flowid : '0;
        o_di = (rst || done_val) ? done_isn : '0;
        chk(tag,
            128'({init_done, o_r0, o_r1, wr_val, o_wa, o_wn, done_val, o_ds, o_df, o_di}),
            128'({e_init, e_r0, e_r1, e_wv, e_wa, e_wn, e_dv, e_ds, e_df, e_di}));
        sn_init = init_done; sn_r0 = rdy0; sn_r1 = rdy1; sn_wv = wr_val; sn_wa = wr_addr;
        sn_wn = wr_num; sn_dv = done_val; sn_ds = done_src; sn_df = done_flowid; sn_di = done_isn;
        sn_hs0 = !rst && v0 && rdy0;
        sn_hs1 = !rst && v1 && rdy1;
        if (sn_hs0) gq.push_back(0);
        if (sn_hs1) gq.push_back(1);
        @(posedge clk);
        if (rst) begin
            c = 0; cleared = 0; ptr = 1'b0; pend.delete();
        end else begin
            if (hs_clr) cleared++;
            if (gnt) begin
                t.src = gsrc;
                t.flow = gsrc ? f1 : f0;
                t.isn = clk_v + (gsrc ? s1 : s0);
                t.written = 1'b0;
                pend.push_back(t);
                ptr = ~gsrc;
            end else if (hs_wr) begin
                t = pend[0]; t.written = 1'b1; pend[0] = t;
            end else if (hs_done) begin
                void'(pend.pop_front());
            end
            c++;
        end
        #1;
    endtask

    int exp_rr[6] = '{1, 0, 1, 0, 1, 1};

    initial begin
        // Reset: everything low
        repeat (3) tick("reset");
        chk("reset_wr_val", 128'(sn_wv), 128'(0));
        rst = 1'b0; wr_rdy = 1'b1; done_rdy = 1'b1;

        // Clear sweep, cycles 0..7
        for (int i = 0; i < E; i++) begin
            tick("clear");
            chk("clear_addr", 128'(sn_wa), 128'(i));
        end
        chk("init_before", 128'(sn_init), 128'(0));
        tick("idle8");
        chk("init_after", 128'(sn_init), 128'(1));
        tick("idle9");

        // Single open at cycle 10 (ISN clock 2)
        v0 = 1'b1; f0 = 3'd5; s0 = 32'h10;
        tick("open_grant");
        chk("open_rdy0", 128'(sn_r0), 128'(1));
        v0 = 1'b0;
        tick("open_write");
        chk("open_wr_addr", 128'(sn_wa), 128'(5));
        chk("open_wr_num", 128'(sn_wn), 128'(32'h12));
        tick("open_done");
        chk("open_done", 128'({sn_dv, sn_ds, sn_df, sn_di}), 128'({1'b1, 1'b0, 3'd5, 32'h12}));

        // Round-robin with both sources requesting continuously
        gq.delete();
        v0 = 1'b1; v1 = 1'b1;
        f0 = AW'($urandom_range(0, E - 1)); s0 = $urandom;
        f1 = AW'($urandom_range(0, E - 1)); s1 = $urandom;
        for (int i = 0; i < 15; i++) begin
            tick("rr");
            if (sn_hs0) begin f0 = AW'($urandom_range(0, E - 1)); s0 = $urandom; end
            if (sn_hs1) begin f1 = AW'($urandom_range(0, E - 1)); s1 = $urandom; end
        end
        v0 = 1'b0;
        repeat (3) tick("rr_single");
        v1 = 1'b0;
        chk("rr_count", 128'(gq.size()), 128'(6));
        for (int i = 0; i < 6; i++) begin
            if (i < gq.size()) chk("rr_src", 128'(gq[i]), 128'(exp_rr[i]));
        end

        // Wrap: grant when the ISN clock reads 0x20
        while (c < 128) tick("idle_wait");
        v1 = 1'b1; f1 = 3'd3; s1 = 32'hFFFF_FFF0;
        tick("wrap_grant");
        chk("wrap_rdy1", 128'(sn_r1), 128'(1));
        v1 = 1'b0;
        tick("wrap_write");
        chk("wrap_wr_num", 128'(sn_wn), 128'(32'h10));
        tick("wrap_done");
        chk("wrap_done_isn", 128'(sn_di), 128'(32'h10));

        // Reset while a write is stalled
        v0 = 1'b1; f0 = 3'd2; s0 = $urandom;
        tick("mid_grant");
        v0 = 1'b0; wr_rdy = 1'b0;
        repeat (2) tick("mid_stall");
        chk("mid_stall_addr", 128'(sn_wa), 128'(2));
        rst = 1'b1;
        repeat (2) begin
            tick("mid_reset");
            chk("mid_no_done", 128'(sn_dv), 128'(0));
        end
        rst = 1'b0; wr_rdy = 1'b1;
        tick("restart");
        chk("restart_wr", 128'({sn_wv, sn_wa, sn_wn, sn_init}), 128'({1'b1, 3'd0, 32'd0, 1'b0}));
        chk("restart_no_done", 128'(sn_dv), 128'(0));

        // Clear backpressure at address 3
        repeat (2) tick("clr_bp");
        wr_rdy = 1'b0;
        repeat (3) begin
            tick("clr_hold");
            chk("clr_hold_addr", 128'(sn_wa), 128'(3));
        end
        wr_rdy = 1'b1;
        tick("clr_release");
        chk("clr_release_addr", 128'(sn_wa), 128'(3));
        for (int i = 4; i < E; i++) begin
            tick("clr_rest");
            chk("clr_rest_addr", 128'(sn_wa), 128'(i));
        end
        chk("clr_bp_init_lo", 128'(sn_init), 128'(0));
        tick("clr_bp_idle");
        chk("clr_bp_init_hi", 128'(sn_init), 128'(1));

        // Randomized traffic with backpressure and occasional reset
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            wr_rdy = ($urandom_range(0, 3) != 0);
            done_rdy = ($urandom_range(0, 2) != 0);
            if (!v0 || sn_hs0) begin
                v0 = $urandom_range(0, 1) == 1;
                f0 = AW'($urandom_range(0, E - 1)); s0 = $urandom;
            end
            if (!v1 || sn_hs1) begin
                v1 = $urandom_range(0, 1) == 1;
                f1 = AW'($urandom_range(0, E - 1)); s1 = $urandom;
            end
            tick("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
